// File: rtl/product_acc_pkg.sv
`default_nettype none
// ============================================================================
// product_acc_pkg : shared types and constants for the product accumulator
// Rev 1.0
// ============================================================================
package product_acc_pkg;

    localparam int PROD_W = 8;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    function automatic int cnt_width(input int n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/product_acc_if.sv
`default_nettype none
// ============================================================================
// product_acc_if : product input / result output handshake bundle
// Rev 1.0
// ============================================================================
interface product_acc_if
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 3
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  result;
    logic [CNT_W-1:0]  result_count;
    logic              result_sat;

    modport master (
        output clear, in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, result, result_count, result_sat
    );

    modport slave (
        input  clear, in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, result, result_count, result_sat
    );
endinterface
`default_nettype wire

// File: rtl/product_accumulator_sat_adder.sv
`default_nettype none
// ============================================================================
// sat_adder : unsigned acc + zero-extended product, clamped to all ones
// Rev 1.0
// ============================================================================
module sat_adder
    import product_acc_pkg::*;
#(
    parameter int ACC_W = 16
)(
    input  wire [ACC_W-1:0]  acc_i,
    input  wire [PROD_W-1:0] operand_i,
    output wire [ACC_W-1:0]  sum_o,
    output wire              ovf_o
);
    wire [ACC_W:0] w_sum;

    assign w_sum = {1'b0, acc_i} + (ACC_W + 1)'(operand_i);
    assign ovf_o = w_sum[ACC_W];
    assign sum_o = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// product_accumulator : saturating sum of up to N_TERMS multiplier products
// Rev 1.0
// ============================================================================
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter  int N_TERMS = 4,
    parameter  int ACC_W   = 16,
    localparam int CNT_W   = cnt_width(N_TERMS)
)(
    input wire          clk,
    input wire          rst,
    product_acc_if.slave bus
);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(N_TERMS - 1);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [ACC_W-1:0] result_q;
    logic [CNT_W-1:0] count_q;
    logic             rsat_q;

    wire [ACC_W-1:0] acc_d;
    wire             ovf;
    wire             sat_d;
    wire [CNT_W-1:0] cnt_d;
    wire             done;

    sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
        .acc_i     (acc_q),
        .operand_i (bus.in_product),
        .sum_o     (acc_d),
        .ovf_o     (ovf)
    );

    assign sat_d = sat_q | ovf;
    assign cnt_d = cnt_q + CNT_W'(1);
    assign done  = bus.in_last || (cnt_q == C_LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            result_q <= '0;
            count_q  <= '0;
            rsat_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_d;
                        cnt_q <= cnt_d;
                        if (done) begin
                            result_q <= acc_d;
                            count_q  <= cnt_d;
                            rsat_q   <= sat_d;
                            state_q  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Result registers stay untouched so they keep their value after handoff.
                    if (bus.out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                        state_q <= ACCUM;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == HOLD);
    assign bus.result       = result_q;
    assign bus.result_count = count_q;
    assign bus.result_sat   = rsat_q;
endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// tb_product_accumulator : directed self-checking bench for product_accumulator
// Rev 1.0
// ============================================================================
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    product_acc_if #(.ACC_W(16), .CNT_W(cnt_width(4))) a_if ();
    product_acc_if #(.ACC_W(10), .CNT_W(cnt_width(8))) b_if ();

    product_accumulator #(.N_TERMS(4), .ACC_W(16)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    product_accumulator #(.N_TERMS(8), .ACC_W(10)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic [7:0] p, input logic last);
        a_if.in_valid   = 1'b1;
        a_if.in_product = p;
        a_if.in_last    = last;
        tick();
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
    endtask

    task automatic beat_b(input logic [7:0] p, input logic last);
        b_if.in_valid   = 1'b1;
        b_if.in_product = p;
        b_if.in_last    = last;
        tick();
        b_if.in_valid = 1'b0;
        b_if.in_last  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_if.clear = 1'b0; a_if.in_valid = 1'b0; a_if.in_product = '0;
        a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
        b_if.clear = 1'b0; b_if.in_valid = 1'b0; b_if.in_product = '0;
        b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 32'(a_if.out_valid), 0);
        chk("rst_in_ready", 32'(a_if.in_ready), 1);
        chk("rst_result", 32'(a_if.result), 0);
        chk("rst_count", 32'(a_if.result_count), 0);
        chk("rst_sat", 32'(a_if.result_sat), 0);

        // Four back-to-back terms auto-complete at N_TERMS
        a_if.out_ready = 1'b1;
        beat_a(8'd225, 1'b0);
        beat_a(8'd225, 1'b0);
        beat_a(8'd225, 1'b0);
        chk("def_not_done_at_3", 32'(a_if.out_valid), 0);
        beat_a(8'd225, 1'b0);
        chk("def_out_valid", 32'(a_if.out_valid), 1);
        chk("def_result", 32'(a_if.result), 900);
        chk("def_count", 32'(a_if.result_count), 4);
        chk("def_sat", 32'(a_if.result_sat), 0);
        chk("def_in_ready_hold", 32'(a_if.in_ready), 0);
        tick();
        chk("def_out_valid_after", 32'(a_if.out_valid), 0);
        chk("def_in_ready_after", 32'(a_if.in_ready), 1);
        chk("def_result_kept", 32'(a_if.result), 900);

        // Early termination
        beat_a(8'd10, 1'b0);
        beat_a(8'd20, 1'b1);
        chk("early_result", 32'(a_if.result), 30);
        chk("early_count", 32'(a_if.result_count), 2);
        chk("early_valid", 32'(a_if.out_valid), 1);
        tick();
        beat_a(8'd7, 1'b1);
        chk("fresh_result", 32'(a_if.result), 7);
        chk("fresh_count", 32'(a_if.result_count), 1);
        tick();

        // Backpressure: held result, offered beat not consumed
        a_if.out_ready = 1'b0;
        beat_a(8'd3, 1'b0);
        beat_a(8'd4, 1'b1);
        a_if.in_valid   = 1'b1;
        a_if.in_product = 8'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_result", 32'(a_if.result), 7);
            chk("bp_in_ready", 32'(a_if.in_ready), 0);
            chk("bp_out_valid", 32'(a_if.out_valid), 1);
        end
        a_if.out_ready = 1'b1;
        a_if.in_last   = 1'b1;
        tick();
        chk("bp_bubble_valid", 32'(a_if.out_valid), 0);
        chk("bp_bubble_ready", 32'(a_if.in_ready), 1);
        tick();
        a_if.in_valid = 1'b0;
        a_if.in_last  = 1'b0;
        chk("bp_new_result", 32'(a_if.result), 99);
        chk("bp_new_count", 32'(a_if.result_count), 1);
        tick();

        // Clear mid-accumulation drops the concurrent beat
        beat_a(8'd50, 1'b0);
        beat_a(8'd60, 1'b0);
        a_if.clear = 1'b1;
        beat_a(8'd70, 1'b0);
        a_if.clear = 1'b0;
        chk("clr_out_valid", 32'(a_if.out_valid), 0);
        chk("clr_in_ready", 32'(a_if.in_ready), 1);
        chk("clr_result", 32'(a_if.result), 0);
        beat_a(8'd5, 1'b0);
        beat_a(8'd6, 1'b1);
        chk("clr_sum_result", 32'(a_if.result), 11);
        chk("clr_sum_count", 32'(a_if.result_count), 2);
        tick();

        // Saturation on the narrow instance
        b_if.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat_b(8'd225, 1'b0);
        chk("sat_not_done_at_7", 32'(b_if.out_valid), 0);
        beat_b(8'd225, 1'b0);
        chk("sat_out_valid", 32'(b_if.out_valid), 1);
        chk("sat_result", 32'(b_if.result), 1023);
        chk("sat_count", 32'(b_if.result_count), 8);
        chk("sat_flag", 32'(b_if.result_sat), 1);
        tick();
        beat_b(8'd1, 1'b0);
        beat_b(8'd1, 1'b1);
        chk("sat_next_result", 32'(b_if.result), 2);
        chk("sat_next_count", 32'(b_if.result_count), 2);
        chk("sat_next_flag", 32'(b_if.result_sat), 0);
        tick();

        // Reset while holding a result
        a_if.out_ready = 1'b0;
        beat_a(8'd100, 1'b1);
        chk("rh_valid", 32'(a_if.out_valid), 1);
        chk("rh_result", 32'(a_if.result), 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_out_valid", 32'(a_if.out_valid), 0);
        chk("rh_result_zero", 32'(a_if.result), 0);
        chk("rh_count_zero", 32'(a_if.result_count), 0);
        chk("rh_in_ready", 32'(a_if.in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
